// File: rtl/eq2_cmp_sched.sv
// Round-robin scheduler sharing one external 2-bit equality comparator between two requesters.
// Operand words are scanned two bits per cycle, LSB pair first, and the scan stops at the first mismatch.
module eq2_cmp_sched #(
    parameter int WIDTH = 8,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic             equal,
    output logic [IW-1:0]    mis_idx,
    output logic             eq_a,
    output logic             eq_b,
    output logic             eq_c,
    output logic             eq_d,
    input  logic             eq_o
);
    localparam int P = WIDTH / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [P-1:0][1:0]  xq;
    logic [P-1:0][1:0]  yq;
    logic [IW-1:0]      k;
    logic               rr;
    logic               cur;
    logic               take;
    logic               sel1;
    logic               scan;

    // rr=1 means requester 1 wins a tie; it always points away from the last winner
    assign sel1 = req1 & (~req0 | rr);
    assign take = (state == S_IDLE) & (req0 | req1);
    assign gnt0 = take & ~sel1;
    assign gnt1 = take & sel1;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign scan = (state == S_SCAN);

    assign eq_a = scan & xq[k][1];
    assign eq_b = scan & xq[k][0];
    assign eq_c = scan & yq[k][1];
    assign eq_d = scan & yq[k][0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            xq      <= '0;
            yq      <= '0;
            k       <= '0;
            rr      <= 1'b0;
            cur     <= 1'b0;
            owner   <= 1'b0;
            equal   <= 1'b0;
            mis_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        xq    <= sel1 ? x1 : x0;
                        yq    <= sel1 ? y1 : y0;
                        cur   <= sel1;
                        rr    <= ~sel1;
                        k     <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!eq_o) begin
                        equal   <= 1'b0;
                        mis_idx <= k;
                        owner   <= cur;
                        state   <= S_DONE;
                    end else if (k == IW'(P - 1)) begin
                        equal   <= 1'b1;
                        mis_idx <= '0;
                        owner   <= cur;
                        state   <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eq2_cmp_sched.sv
// Directed bench for eq2_cmp_sched: inputs change on the falling edge, outputs are checked 1ns later.
module tb_eq2_cmp_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] x0, y0, x1, y1;
    logic       gnt0, gnt1, busy, done, owner, equal;
    logic [1:0] mis_idx;
    logic       eq_a, eq_b, eq_c, eq_d, eq_o;
    int         checks = 0;
    int         errors = 0;

    eq2_cmp_sched #(.WIDTH(8), .IW(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .owner(owner), .equal(equal), .mis_idx(mis_idx),
        .eq_a(eq_a), .eq_b(eq_b), .eq_c(eq_c), .eq_d(eq_d),
        .eq_o(eq_o)
    );

    // Behavioural model of the shared comparator
    assign eq_o = ({eq_a, eq_b} == {eq_c, eq_d});

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pins(input string tag, input logic [3:0] exp);
        chk(tag, {eq_a, eq_b, eq_c, eq_d}, exp);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        cyc(); cyc(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_equal", equal, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mis", mis_idx, 0);
        chk_pins("rst_pins", 4'b0000);
        rst = 1'b0;

        // Full match from requester 0
        cyc(); req0 = 1'b1; x0 = 8'hA5; y0 = 8'hA5; #1;
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_idle_busy", busy, 0);
        chk_pins("t1_idle_pins", 4'b0000);
        cyc(); req0 = 1'b0; #1;
        chk("t1_busy", busy, 1);
        chk_pins("t1_p0", 4'b0101);
        cyc(); #1; chk_pins("t1_p1", 4'b0101);
        cyc(); #1; chk_pins("t1_p2", 4'b1010);
        cyc(); #1; chk_pins("t1_p3", 4'b1010);
        chk("t1_nodone", done, 0);
        cyc(); #1;
        chk("t1_done", done, 1);
        chk("t1_equal", equal, 1);
        chk("t1_owner", owner, 0);
        chk("t1_mis", mis_idx, 0);
        chk("t1_done_busy", busy, 1);
        chk_pins("t1_done_pins", 4'b0000);
        cyc(); #1;
        chk("t1_after_done", done, 0);
        chk("t1_after_busy", busy, 0);
        chk("t1_hold_equal", equal, 1);

        // Requester 1, mismatch on pair 0
        cyc(); req1 = 1'b1; x1 = 8'h3C; y1 = 8'h3D; #1;
        chk("t2_gnt1", gnt1, 1);
        chk("t2_gnt0", gnt0, 0);
        cyc(); req1 = 1'b0; #1;
        chk_pins("t2_p0", 4'b0001);
        chk("t2_busy1", busy, 1);
        chk("t2_nodone", done, 0);
        cyc(); #1;
        chk("t2_done", done, 1);
        chk("t2_equal", equal, 0);
        chk("t2_mis", mis_idx, 0);
        chk("t2_owner", owner, 1);
        chk("t2_busy2", busy, 1);
        cyc(); #1;
        chk("t2_busy_end", busy, 0);

        // Mismatch on last pair; operands change after capture
        cyc(); req0 = 1'b1; x0 = 8'h12; y0 = 8'h52; #1;
        chk("t3_gnt0", gnt0, 1);
        cyc(); req0 = 1'b0; x0 = 8'hFF; y0 = 8'h00; #1;
        chk_pins("t3_p0", 4'b1010);
        cyc(); #1; chk_pins("t3_p1", 4'b0000);
        cyc(); #1; chk_pins("t3_p2", 4'b0101);
        cyc(); #1; chk_pins("t3_p3", 4'b0001);
        chk("t3_nodone", done, 0);
        cyc(); #1;
        chk("t3_done", done, 1);
        chk("t3_equal", equal, 0);
        chk("t3_mis", mis_idx, 3);
        chk("t3_owner", owner, 0);
        chk_pins("t3_done_pins", 4'b0000);
        cyc(); #1;
        chk("t3_busy_end", busy, 0);
        chk("t3_hold_mis", mis_idx, 3);

        // Both requesters held high from reset: round-robin 0,1,0,1
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        x0 = 8'hA5; y0 = 8'hA5; x1 = 8'h3C; y1 = 8'h3C;
        #1;
        chk("t4_rst_mis", mis_idx, 0);
        chk("t4_rst_equal", equal, 0);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("t4_gnt0_%0d", g), gnt0, (g % 2 == 0));
            chk($sformatf("t4_gnt1_%0d", g), gnt1, (g % 2 == 1));
            repeat (4) begin
                cyc(); #1;
                chk($sformatf("t4_nognt_%0d", g), gnt0 | gnt1, 0);
            end
            cyc(); #1;
            chk($sformatf("t4_done_%0d", g), done, 1);
            chk($sformatf("t4_owner_%0d", g), owner, g % 2);
            chk($sformatf("t4_nognt_done_%0d", g), gnt0 | gnt1, 0);
            cyc();
            if (g == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        #1;
        chk("t4_idle_nognt", gnt0 | gnt1, 0);

        // Reset in the middle of a scan aborts it
        cyc(); req0 = 1'b1; x0 = 8'hA5; y0 = 8'hA5; #1;
        chk("t5_gnt0", gnt0, 1);
        cyc(); req0 = 1'b0;
        cyc(); rst = 1'b1; #1;
        chk("t5_scan_busy", busy, 1);
        chk_pins("t5_scan_p1", 4'b0101);
        cyc(); rst = 1'b0; #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_equal", equal, 0);
        chk("t5_owner", owner, 0);
        chk("t5_mis", mis_idx, 0);
        chk_pins("t5_pins", 4'b0000);
        cyc(); #1;
        chk("t5_nodone", done, 0);
        req1 = 1'b1; x1 = 8'h00; y1 = 8'h10; #1;
        chk("t5_gnt1", gnt1, 1);
        chk("t5_gnt0", gnt0, 0);
        cyc(); req1 = 1'b0; #1; chk_pins("t5_p0", 4'b0000);
        cyc(); #1; chk_pins("t5_p1", 4'b0000);
        cyc(); #1; chk_pins("t5_p2", 4'b0001);
        cyc(); #1;
        chk("t5_fdone", done, 1);
        chk("t5_fequal", equal, 0);
        chk("t5_fmis", mis_idx, 2);
        chk("t5_fowner", owner, 1);
        cyc(); #1;
        chk("t5_fbusy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
